// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: hazard and forwarding controller for the 5-stage pipeline.
//
// Each in-flight instruction in E, M and W has a shadow copy of its
// destination register and its Tnew. These copies are compared against the
// Tuse of the instruction in D. The block produces the freeze/bubble stall
// and the D-stage forwarding selects. It also owns the mult/div busy
// down-counter that holds back HI/LO consumers.
//
// Optional build macro HAZARD_PERF_EN adds two free-running performance
// counters: stall_cycles and md_stall_cycles.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [4:0]       e_dst_q, e_dst_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic             e_md_start_q, e_md_start_d;
  logic             e_md_div_q, e_md_div_d;
  logic [4:0]       m_dst_q, m_dst_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       w_dst_q, w_dst_d;
  logic [1:0]       w_tnew_q, w_tnew_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic stall_rs, stall_rt, stall_md;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A source stalls when E or M will not have its value ready in time.
  // W is always ready thanks to the register-file write-through bypass.
  function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse);
    logic hit;
    hit = 1'b0;
    if (d_valid && (s != 5'd0) && (tuse != TUSE_NONE)) begin
      if ((e_dst_q == s) && (e_tnew_q > tuse)) hit = 1'b1;
      if ((m_dst_q == s) && (m_tnew_q > tuse)) hit = 1'b1;
    end
    return hit;
  endfunction

  // The youngest stage that writes s decides. If its result is still
  // pending, read the GRF (0) rather than falling back to an older,
  // stale producer.
  function automatic logic [1:0] fwd_sel(input logic [4:0] s);
    logic [1:0] sel;
    sel = 2'd0;
    if (s != 5'd0) begin
      if (e_dst_q == s)      sel = (e_tnew_q == 2'd0) ? 2'd1 : 2'd0;
      else if (m_dst_q == s) sel = (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
      else if (w_dst_q == s) sel = (w_tnew_q == 2'd0) ? 2'd3 : 2'd0;
    end
    return sel;
  endfunction

  // Stall and forwarding decisions, purely from current shadows and D inputs.
  always_comb begin
    stall_rs = src_hazard(d_rs, d_tuse_rs);
    stall_rt = src_hazard(d_rt, d_tuse_rt);
    md_busy  = (md_cnt_q != '0);
    stall_md = d_valid && d_md_use && (e_md_start_q || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
    fwd_rs   = fwd_sel(d_rs);
    fwd_rt   = fwd_sel(d_rt);
  end

  // Shadow pipeline advance: D enters E unless invalid or stalled; E->M->W never freeze.
  always_comb begin
    e_dst_d      = 5'd0;
    e_tnew_d     = 2'd0;
    e_md_start_d = 1'b0;
    e_md_div_d   = 1'b0;
    if (d_valid && !stall) begin
      e_dst_d      = d_dst;
      e_tnew_d     = d_tnew;
      e_md_start_d = d_md_start;
      e_md_div_d   = d_md_div;
    end
    m_dst_d  = e_dst_q;
    m_tnew_d = tnew_dec(e_tnew_q);
    w_dst_d  = m_dst_q;
    w_tnew_d = tnew_dec(m_tnew_q);
  end

  // md busy down-counter: loads as the md instruction leaves E, then counts to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start_q) begin
      md_cnt_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  // State registers; reset turns every stage into a bubble and idles the md unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q      <= 5'd0;
      e_tnew_q     <= 2'd0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_dst_q      <= 5'd0;
      m_tnew_q     <= 2'd0;
      w_dst_q      <= 5'd0;
      w_tnew_q     <= 2'd0;
      md_cnt_q     <= '0;
    end else begin
      e_dst_q      <= e_dst_d;
      e_tnew_q     <= e_tnew_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
      m_dst_q      <= m_dst_d;
      m_tnew_q     <= m_tnew_d;
      w_dst_q      <= w_dst_d;
      w_tnew_q     <= w_tnew_d;
      md_cnt_q     <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  // Performance counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, stall_md};
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= 32'd0;
      md_stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign md_stall_cycles = md_stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Shadows the destination register and Tnew of each in-flight instruction in E, M and W, and compares them against the Tuse of the instruction in D.
- Produces the freeze/bubble stall signal and the D-stage forwarding selects feeding the register-file read path.
- Also sequences the multiply/divide unit with a busy countdown. HI/LO consumers stall until the countdown expires.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu leaves E.
- DIV_CYCLES, 10: busy cycles after a div/divu leaves E.
- CNT_W, 4: width of the md busy counter. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D holds a real instruction
- d_rs  in  5  source register 1 of the D instruction
- d_rt  in  5  source register 2 of the D instruction
- d_tuse_rs  in  2  cycles until rs is needed; 3 = not used
- d_tuse_rt  in  2  cycles until rt is needed; 3 = not used
- d_dst  in  5  destination register; 0 = no write
- d_tnew  in  2  cycles until the result exists, counted on entry to E
- d_md_start  in  1  D instruction is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: 1 = divide, 0 = multiply
- d_md_use  in  1  D instruction reads or writes HI/LO, or starts the md unit
- stall  out  1  freeze PC and F/D; insert a bubble into D/E
- fwd_rs  out  2  rs source: 0 GRF, 1 E, 2 M, 3 W
- fwd_rt  out  2  rt source: same encoding as fwd_rs
- md_busy  out  1  md counter is non-zero

Behaviour:
- State
  - Per-stage shadow registers for E, M and W, each holding {dst[4:0], tnew[1:0]}.
  - E additionally holds md_start and md_div.
  - One md counter, CNT_W bits wide.
- Reset
  - All stages become bubbles: dst=0, tnew=0, md bits 0. md counter = 0.
  - Consequence: stall=0, fwd_rs=fwd_rt=0, md_busy=0 in the cycle after reset is sampled.
- Stage advance, every clock when not in reset
  - E <= D fields when (d_valid && !stall); otherwise E <= bubble.
  - M <= E with tnew decremented, saturating at 0. md bits are not carried into M.
  - W <= M with tnew decremented, saturating at 0.
  - Stall never freezes E, M or W.
- Register hazard detection, combinational, per source s in {rs, rt}
  - Applies only when d_valid, s!=0 and tuse_s!=3.
  - stall_s = (E.dst==s && E.tnew>tuse_s) || (M.dst==s && M.tnew>tuse_s).
  - W never causes a stall; the GRF write-through bypass covers it.
- Forwarding select
  - The youngest stage whose dst==s and dst!=0 decides, in priority E > M > W.
  - If that stage's tnew==0, select it (1, 2 or 3); otherwise select 0.
  - Never fall through to an older stage while a younger stage holds a pending write to s.
  - s==0 always gives 0.
- md sequencing
  - When E.md_start=1, the counter loads DIV_CYCLES (E.md_div=1) or MULT_CYCLES at that clock edge.
  - Otherwise the counter decrements if non-zero.
  - md_busy = (counter != 0).
  - stall_md = d_valid && d_md_use && (E.md_start || md_busy).
- stall = stall_rs || stall_rt || stall_md. It is purely combinational from the current state and D inputs.
- Simultaneous events
  - A new md start cannot reach E while the unit is busy, because stall_md blocks it.
  - Reset overrides load and decrement in the same cycle.
- Reset mid-operation flushes all shadows and the counter. There is no residual stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds output ports stall_cycles[31:0] and md_stall_cycles[31:0].
  - stall_cycles counts cycles with stall=1; md_stall_cycles counts cycles with stall_md=1.
  - Both counters wrap modulo 2^32 and are cleared by reset.
- When undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Load-use: lw $8 in E (dst=8, tnew=2), D addu rs=8 (tuse_rs=1).
  - stall=1 for exactly 1 cycle.
  - The lw then sits in M with tnew=1, so stall=0 and fwd_rs=0 (pending in M).
  - Next cycle: fwd_rs=3 (from W).
- ALU chain: addu $9 in E (tnew=1), D beq rs=9 (tuse=0).
  - stall=1 for 1 cycle, then fwd_rs=2.
  - With tuse=1 instead: no stall; fwd_rs=0 that cycle.
- Priority: E.dst=10 with tnew=0 and M.dst=10 with tnew=0 → fwd_rs=1. Any source with d_rs=0 → fwd_rs=0 and no stall.
- md: mult passes E, then D mflo (d_md_use=1).
  - md_busy is high 5 cycles.
  - stall is high from the E cycle through the last busy cycle (6 cycles).
  - Repeat with div → 11 cycles.
- Reset while the md counter=7 and E holds a load: after the reset edge, md_busy=0, stall=0 and fwd=0 with any D inputs.
- With HAZARD_PERF_EN: the load-use scenario followed by the mult scenario → stall_cycles=7, md_stall_cycles=6.
